// File: rtl/block_sync.sv
// block_sync: receive-side 66b block synchronizer.
// Finds block alignment in a bit-shifted coded stream by hunting for valid
// 2-bit sync headers, then delivers aligned blocks plus lock status.
//
// Optional build macro: BLOCK_SYNC_ERR_CNT_EN adds o_sh_err_count, a
// saturating count of invalid headers seen while locked (reset-only clear).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_UNLOCK | hunting: counting consecutive valid headers at this offset
// S_SLIP   | one cycle: advance bit offset, clear counters
// S_LOCK   | aligned: monitoring invalid headers per header window
module block_sync #(
  parameter int LEN_CODED_BLOCK = 66,
  parameter int LOCK_VALID      = 64,
  parameter int WINDOW          = 1024,
  parameter int MAX_INVALID     = 65
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic [LEN_CODED_BLOCK-1:0] i_data,
  output logic [LEN_CODED_BLOCK-1:0] o_data,
  output logic                       o_valid,
  output logic                       o_block_lock,
`ifdef BLOCK_SYNC_ERR_CNT_EN
  output logic [15:0]                o_sh_err_count,
`endif
  output logic [6:0]                 o_offset
);

  localparam int SH_W  = $clog2(WINDOW) + 1;
  localparam int INV_W = $clog2(MAX_INVALID) + 1;

  typedef enum logic [1:0] {S_UNLOCK, S_SLIP, S_LOCK} state_t;

  state_t                       r_state;
  logic [LEN_CODED_BLOCK-1:0]   r_data_d1;
  logic [SH_W-1:0]              r_sh_cnt;
  logic [INV_W-1:0]             r_inv_cnt;

  logic [2*LEN_CODED_BLOCK-1:0] w_window;
  logic [6:0]                   w_rshift;
  logic [LEN_CODED_BLOCK-1:0]   w_aligned;
  logic                         w_sh_valid;
  logic [SH_W-1:0]              w_sh_cnt_inc;
  logic [INV_W-1:0]             w_inv_cnt_inc;
  logic                         w_lose_lock;
  logic [6:0]                   w_offset_next;

  // Offset k picks the 66 bits starting k bits into {previous, current};
  // a right shift by (66-k) then truncation lands exactly that slice.
  assign w_window      = {r_data_d1, i_data};
  assign w_rshift      = 7'(LEN_CODED_BLOCK) - o_offset;
  assign w_aligned     = LEN_CODED_BLOCK'(w_window >> w_rshift);
  assign w_sh_valid    = w_aligned[LEN_CODED_BLOCK-1] ^ w_aligned[LEN_CODED_BLOCK-2];
  assign w_sh_cnt_inc  = r_sh_cnt + SH_W'(1);
  assign w_inv_cnt_inc = r_inv_cnt + {{(INV_W-1){1'b0}}, ~w_sh_valid};
  assign w_lose_lock   = (r_state == S_LOCK) && (w_inv_cnt_inc == INV_W'(MAX_INVALID));
  assign w_offset_next = (o_offset == 7'(LEN_CODED_BLOCK - 1)) ? 7'd0 : o_offset + 7'd1;

  // Datapath registers and lock FSM; everything advances only on enabled cycles.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_UNLOCK;
      r_data_d1    <= '0;
      r_sh_cnt     <= '0;
      r_inv_cnt    <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_block_lock <= 1'b0;
      o_offset     <= 7'd0;
    end else if (i_enable) begin
      r_data_d1 <= i_data;
      o_data    <= w_aligned;
      // valid falls on the same edge that lock falls
      o_valid   <= (r_state == S_LOCK) && !w_lose_lock;
      case (r_state)
        S_UNLOCK: begin
          if (w_sh_valid) begin
            if (w_sh_cnt_inc == SH_W'(LOCK_VALID)) begin
              r_state      <= S_LOCK;
              o_block_lock <= 1'b1;
              r_sh_cnt     <= '0;
              r_inv_cnt    <= '0;
            end else begin
              r_sh_cnt <= w_sh_cnt_inc;
            end
          end else begin
            r_state <= S_SLIP;
          end
        end
        S_SLIP: begin
          o_offset  <= w_offset_next;
          r_sh_cnt  <= '0;
          r_inv_cnt <= '0;
          r_state   <= S_UNLOCK;
        end
        S_LOCK: begin
          if (w_lose_lock) begin
            r_state      <= S_SLIP;
            o_block_lock <= 1'b0;
            r_sh_cnt     <= '0;
            r_inv_cnt    <= '0;
          end else if (w_sh_cnt_inc == SH_W'(WINDOW)) begin
            r_sh_cnt  <= '0;
            r_inv_cnt <= '0;
          end else begin
            r_sh_cnt  <= w_sh_cnt_inc;
            r_inv_cnt <= w_inv_cnt_inc;
          end
        end
        default: r_state <= S_UNLOCK;
      endcase
    end else begin
      o_valid <= 1'b0;
    end
  end

`ifdef BLOCK_SYNC_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  // Saturating tally of invalid headers observed while locked.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_err_cnt <= 16'd0;
    end else if (i_enable && (r_state == S_LOCK) && !w_sh_valid && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign o_sh_err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_block_sync.sv
// Directed bench for block_sync: builds a bit-shifted coded stream from
// random blocks, queues each block as it is sent and compares it when the
// DUT emits the matching aligned word.
module tb_block_sync;
  localparam int L = 66;

  logic         i_clock = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_enable = 1'b0;
  logic [L-1:0] i_data = '0;
  logic [L-1:0] o_data;
  logic         o_valid;
  logic         o_block_lock;
  logic [6:0]   o_offset;
`ifdef BLOCK_SYNC_ERR_CNT_EN
  logic [15:0]  o_sh_err_count;
`endif

  int checks = 0;
  int failures = 0;
  logic [L-1:0] exp_q[$];
  logic [L-1:0] prev_blk = '0;
  logic [L-1:0] last_exp = '0;
  int cur_d = 0;

  always #5 i_clock = ~i_clock;

  block_sync dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_data       (i_data),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_block_lock (o_block_lock),
`ifdef BLOCK_SYNC_ERR_CNT_EN
    .o_sh_err_count (o_sh_err_count),
`endif
    .o_offset     (o_offset)
  );

  task automatic chk_vec(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_off(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step_raw(input logic [L-1:0] w, input logic en);
    i_data = w;
    i_enable = en;
    @(posedge i_clock);
    #1;
  endtask

  function automatic logic [L-1:0] mk_blk(input bit bad);
    logic [L-1:0] b;
    b[63:0] = {$urandom, $urandom};
    if (bad) b[65:64] = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
    else     b[65:64] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
    return b;
  endfunction

  // Send one block on a stream delayed by cur_d bits; the block emitted by
  // the DUT on this edge is the one sent on the previous call.
  task automatic send(input bit bad);
    logic [L-1:0]   blk;
    logic [L-1:0]   w;
    logic [L-1:0]   exp;
    logic [2*L-1:0] cat;
    blk = mk_blk(bad);
    cat = {prev_blk, blk} << (L - cur_d);
    w = cat[2*L-1:L];
    exp_q.push_back(blk);
    step_raw(w, 1'b1);
    prev_blk = blk;
    if (exp_q.size() >= 2) begin
      exp = exp_q.pop_front();
      last_exp = exp;
      chk_vec("o_data", o_data, exp);
    end
  endtask

  task automatic do_reset_mid();
    #3;
    i_reset = 1'b0;
    #1;
    chk_vec("rst_data", o_data, '0);
    chk_bit("rst_valid", o_valid, 1'b0);
    chk_bit("rst_lock", o_block_lock, 1'b0);
    chk_off("rst_offset", o_offset, 7'd0);
    @(posedge i_clock);
    #1;
    i_reset = 1'b1;
  endtask

  // All-zero words force a slip every two cycles, stepping the offset to
  // d-1 (or 65 for d=0); the stream starts on the final slip cycle.
  task automatic acquire(input int d);
    int nz;
    nz = (d == 0) ? 2 * L - 1 : 2 * d - 1;
    cur_d = d;
    exp_q.delete();
    prev_blk = '0;
    for (int i = 0; i < nz; i++) step_raw('0, 1'b1);
    chk_off("offset_pre", o_offset, (d == 0) ? 7'(L - 1) : 7'(d - 1));
    chk_bit("lock_pre", o_block_lock, 1'b0);
    send(1'b0);
    chk_off("offset_slip", o_offset, 7'(d));
    for (int m = 1; m <= 70; m++) begin
      send(1'b0);
      chk_bit("acq_lock", o_block_lock, m >= 64);
      chk_bit("acq_valid", o_valid, m >= 65);
      chk_off("acq_offset", o_offset, 7'(d));
    end
  endtask

  initial begin
    #7;
    do_reset_mid();

    // offset 0: full offset wrap 65 -> 0, then lock
    acquire(0);

    // windows: 64 bad ending window 0, 64 starting window 1, then
    // 64 + the 1024th header bad in window 2 -> slip on the boundary
    for (int m = 71; m <= 3136; m++) begin
      bit bad;
      bad = (m >= 1024 && m <= 1151) || (m >= 2112 && m <= 2175) || (m == 3135);
      send(bad);
      chk_bit("win_lock", o_block_lock, (m - 1) != 3135);
      chk_bit("win_valid", o_valid, (m - 1) != 3135);
    end
    send(1'b0);
    chk_off("win_slip_offset", o_offset, 7'd1);
    chk_bit("win_slip_lock", o_block_lock, 1'b0);
`ifdef BLOCK_SYNC_ERR_CNT_EN
    chk_vec("err_cnt_a", L'(o_sh_err_count), L'(193));
`endif

    do_reset_mid();

    // 10-bit delayed stream
    acquire(10);
    for (int m = 71; m <= 134; m++) begin
      send(1'b1);
      chk_bit("pre_freeze_lock", o_block_lock, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      step_raw('0, 1'b0);
      chk_bit("frz_valid", o_valid, 1'b0);
      chk_bit("frz_lock", o_block_lock, 1'b1);
      chk_off("frz_offset", o_offset, 7'd10);
      chk_vec("frz_data", o_data, last_exp);
    end
    for (int m = 135; m <= 144; m++) begin
      send(1'b0);
      chk_bit("post_freeze_lock", o_block_lock, 1'b1);
      chk_bit("post_freeze_valid", o_valid, 1'b1);
      chk_off("post_freeze_offset", o_offset, 7'd10);
    end

    // reset while locked
    do_reset_mid();

    // re-lock, then 65 consecutive invalid headers lose lock
    acquire(10);
    for (int m = 71; m <= 136; m++) begin
      send(m <= 135);
      chk_bit("inv_lock", o_block_lock, (m - 1) != 135);
      chk_bit("inv_valid", o_valid, (m - 1) != 135);
    end
    send(1'b0);
    chk_off("inv_slip_offset", o_offset, 7'd11);
`ifdef BLOCK_SYNC_ERR_CNT_EN
    chk_vec("err_cnt_b", L'(o_sh_err_count), L'(65));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/block_sync.md
Name: block_sync

Overview:
Receive-side 66b block synchronizer at the head of rx_modules, directly downstream of the tx_modules scrambled output and upstream of the descrambler/decoder.
- Recovers 66-bit block alignment from an arbitrarily bit-shifted coded stream using the sync-header lock FSM (lock after 64 good headers, lose lock on 65 bad in a 1024-block window).
- Outputs aligned blocks plus lock status to the descrambler.

Parameters:
LEN_CODED_BLOCK, 66, coded block width; sync header = bits [LEN_CODED_BLOCK-1 : LEN_CODED_BLOCK-2]
LOCK_VALID, 64, consecutive valid headers required to declare lock
WINDOW, 1024, headers per monitoring window while locked
MAX_INVALID, 65, invalid headers within one window that force loss of lock

Ports:
i_clock  input  1  system clock
i_reset  input  1  asynchronous, active-low reset
i_enable  input  1  block-rate qualifier; low freezes all state
i_data  input  66  raw coded word from tx_modules scrambler, any bit alignment
o_data  output  66  aligned coded block
o_valid  output  1  o_data is an aligned block sampled while locked
o_block_lock  output  1  block lock status
o_offset  output  7  current bit-slip offset, 0..65

Behaviour:
- Reset (i_reset=0, async): data_d1, o_data=0; o_valid=0; o_block_lock=0; o_offset=0; counters=0; FSM=S_UNLOCK.
- Datapath:
  - On enabled cycle: data_d1<=i_data.
  - window = {data_d1, i_data} (132 bits).
  - aligned = window[131-o_offset -: 66]; offset 0 selects data_d1.
  - o_data<=aligned on enabled cycles; latency 2 enabled cycles at offset 0.
- Header check, combinational on aligned: valid iff aligned[65:64] is 2'b01 or 2'b10; 00/11 invalid.
- FSM evaluates one header per enabled cycle. i_enable=0 holds FSM, counters, offset and data; o_valid<=0.
- S_UNLOCK:
  - valid header: sh_cnt++. If this is the LOCK_VALID-th valid header, go S_LOCK; o_block_lock<=1 next cycle; clear counters.
  - invalid header: go S_SLIP.
- S_SLIP, exactly 1 enabled cycle:
  - o_offset<=(o_offset==65)?0:o_offset+1.
  - Clear counters; header ignored; then S_UNLOCK.
- S_LOCK:
  - Every header: sh_cnt++; invalid: inv_cnt++.
  - inv_cnt reaching MAX_INVALID: go S_SLIP, o_block_lock<=0 in the same edge.
  - Else if sh_cnt reaches WINDOW: clear both counters, stay locked.
  - Simultaneous (WINDOW-th header is the MAX_INVALID-th invalid): slip wins.
- o_valid<=i_enable & (state==S_LOCK), registered alongside o_data; o_valid drops the cycle lock drops.
- Counter widths: sh_cnt clog2(WINDOW)+1; inv_cnt clog2(MAX_INVALID)+1; no wrap before compare.
- Reset mid-operation: immediate return to reset values; alignment is re-acquired from offset 0.

Optional Feature:
BLOCK_SYNC_ERR_CNT_EN
- Defined: adds output o_sh_err_count [15:0]. Increments on each invalid header sampled in S_LOCK; saturates at 16'hFFFF; cleared only by reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Reset asserted low mid-simulation -> o_block_lock=0, o_valid=0, o_offset=0, o_data=0 immediately, without waiting for a clock edge.
2. tx_modules scrambled stream at offset 0, enable continuous -> o_block_lock=1 on the cycle after the 64th valid header; o_offset stays 0; o_data equals the tx block delayed 2 cycles.
3. Same stream delayed by 10 bits across words -> o_offset walks through slips, final o_offset=10, o_block_lock=1; o_data matches the tx blocks bit-exactly.
4. Locked; 64 headers forced to 2'b00 within one window -> lock held. Repeat with 65 invalid -> o_block_lock=0 one cycle after the 65th; o_offset increments by 1.
5. Locked; 64 invalid in window N and 64 in window N+1 -> counters clear at the 1024 boundary and lock is never lost. With the 1024th header as the 65th invalid -> slip occurs.
6. o_offset=65, then an invalid header -> o_offset wraps to 0. Toggle i_enable 0 for 5 cycles while locked -> counters and offset frozen, o_valid=0, lock held.
